// File: rtl/wordline_sequencer.sv
// Clocked wordline sequencer: latches a real-valued row address, then runs
// precharge -> one-hot wordline pulse -> recovery. Optional WL_BOOST_EN overdrives the wordline.
module wordline_sequencer #(
  parameter int  ROWS       = 16,
  parameter int  PRE_CYCLES = 1,
  parameter int  WL_PULSE   = 2,
  parameter real VDD        = 1.5,
  parameter real VSS        = 0.0,
  parameter real VTH        = 0.8,
  parameter real WL_BOOST   = 0.3,
  localparam int AW         = $clog2(ROWS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  real  addr [0:AW-1],
  output logic ready,
  output logic done,
  output logic err,
  output real  precharge,
  output real  wl [0:ROWS-1]
);

  localparam int MAXC = (PRE_CYCLES > WL_PULSE) ? PRE_CYCLES : WL_PULSE;
  localparam int CW   = $clog2(MAXC + 1);

`ifdef WL_BOOST_EN
  localparam real VWL = VDD + WL_BOOST;
`else
  localparam real VWL = VDD;
  logic unused_boost;
  assign unused_boost = (WL_BOOST > 0.0);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRECH,
    ACTIVE,
    RECOVER
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addrBits;

  always_comb begin
    addrBits = '0;
    for (int i = 0; i < AW; i++) begin
      addrBits[i] = (addr[i] >= VTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The address is only sampled in IDLE, so later addr changes cannot leak into a running access.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          row_d = addrBits;
          if (32'(addrBits) < ROWS) begin
            state_d = PRECH;
            cnt_d   = CW'(PRE_CYCLES - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRECH: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
          cnt_d   = CW'(WL_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from registered state so precharge and wordlines never overlap.
  always_comb begin
    ready     = (state_q == IDLE);
    done      = done_q;
    err       = err_q;
    precharge = (state_q == PRECH) ? VDD : VSS;
    for (int i = 0; i < ROWS; i++) begin
      wl[i] = VSS;
      if ((state_q == ACTIVE) && (row_q == AW'(i))) begin
        wl[i] = VWL;
      end
    end
  end

endmodule

// File: tb/tb_wordline_sequencer.sv
// Scoreboard bench for wordline_sequencer: a ROWS=16 instance for timing/decode and a
// ROWS=12 instance for out-of-range handling. Define WL_BOOST_EN to check the boosted rail.
module tb_wordline_sequencer;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam int  PRE = 1;
  localparam int  PULSE = 2;
`ifdef WL_BOOST_EN
  localparam real VWL_EXP = 1.8;
`else
  localparam real VWL_EXP = 1.5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req, req12;
  real  addr [0:3];
  real  addr12 [0:3];
  logic ready, done, err, ready12, done12, err12;
  real  precharge, precharge12;
  real  wl [0:15];
  real  wl12 [0:11];

  wordline_sequencer #(.ROWS(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
    .ready(ready), .done(done), .err(err), .precharge(precharge), .wl(wl)
  );

  wordline_sequencer #(.ROWS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .req(req12), .addr(addr12),
    .ready(ready12), .done(done12), .err(err12), .precharge(precharge12), .wl(wl12)
  );

  typedef struct {
    bit ready;
    bit done;
    bit err;
    bit pre;
    int wlIdx;
  } exp_t;

  exp_t expQ[$];
  exp_t q12[$];
  int   checks = 0;
  int   failures = 0;
  bit   curReady = 1'b1;
  bit   cur12Ready = 1'b1;
  int   addrV = 0;
  int   addr12V = 0;

  function automatic exp_t idleRec();
    exp_t r;
    r.ready = 1'b1; r.done = 1'b0; r.err = 1'b0; r.pre = 1'b0; r.wlIdx = -1;
    return r;
  endfunction

  function automatic bit realEq(real a, real b);
    return ((a - b) < 1e-6) && ((b - a) < 1e-6);
  endfunction

  task automatic chkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chkReal(input string tag, input real obs, input real expv);
    checks++;
    assert (realEq(obs, expv) === 1'b1) else begin
      failures++;
      $error("[TB] FAIL %s: observed %f expected %f at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic pushRec(input int sel, input exp_t r);
    if (sel == 0) expQ.push_back(r);
    else q12.push_back(r);
  endtask

  // Expected per-cycle outputs for one accepted request, starting the cycle after the accept edge.
  task automatic pushAccess(input int sel, input int row, input int rows);
    exp_t r;
    r = idleRec();
    if (row >= rows) begin
      r.err = 1'b1;
      pushRec(sel, r);
      return;
    end
    r.ready = 1'b0;
    r.pre = 1'b1;
    for (int i = 0; i < PRE; i++) pushRec(sel, r);
    r.pre = 1'b0;
    r.wlIdx = row;
    for (int i = 0; i < PULSE; i++) pushRec(sel, r);
    r.wlIdx = -1;
    pushRec(sel, r);
    r = idleRec();
    r.done = 1'b1;
    pushRec(sel, r);
  endtask

  task automatic checkOutput(input exp_t e);
    int n;
    n = 0;
    chkBit("ready", ready, e.ready);
    chkBit("done", done, e.done);
    chkBit("err", err, e.err);
    chkReal("precharge", precharge, e.pre ? VDD : VSS);
    for (int i = 0; i < 16; i++) begin
      chkReal($sformatf("wl[%0d]", i), wl[i], (i == e.wlIdx) ? VWL_EXP : VSS);
      if (wl[i] > VSS + 0.1) n++;
    end
    chkBit("onehot", (n <= 1), 1'b1);
    chkBit("mutex", !((precharge > VSS + 0.1) && (n > 0)), 1'b1);
  endtask

  task automatic check12(input exp_t e);
    chkBit("ready12", ready12, e.ready);
    chkBit("done12", done12, e.done);
    chkBit("err12", err12, e.err);
    chkReal("precharge12", precharge12, e.pre ? VDD : VSS);
    for (int i = 0; i < 12; i++) begin
      chkReal($sformatf("wl12[%0d]", i), wl12[i], (i == e.wlIdx) ? VWL_EXP : VSS);
    end
  endtask

  task automatic applyStimulus(input bit r, input int a, input real hi = VDD, input real lo = VSS);
    req = r;
    addrV = a;
    for (int i = 0; i < 4; i++) addr[i] = ((a >> i) & 1) != 0 ? hi : lo;
  endtask

  task automatic apply12(input bit r, input int a);
    req12 = r;
    addr12V = a;
    for (int i = 0; i < 4; i++) addr12[i] = ((a >> i) & 1) != 0 ? VDD : VSS;
  endtask

  // Model the accept on the coming edge, then sample both DUTs 1 ns after it.
  task automatic stepCycle();
    exp_t e;
    exp_t e12;
    if (req && curReady && rst_n) pushAccess(0, addrV, 16);
    if (req12 && cur12Ready && rst_n) pushAccess(1, addr12V, 12);
    @(posedge clk);
    #1;
    e = (expQ.size() > 0) ? expQ.pop_front() : idleRec();
    e12 = (q12.size() > 0) ? q12.pop_front() : idleRec();
    checkOutput(e);
    check12(e12);
    curReady = e.ready;
    cur12Ready = e12.ready;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0);
    apply12(0, 0);
    #2;
    checkOutput(idleRec());
    check12(idleRec());
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic access row 5");
    applyStimulus(1, 5);
    stepCycle();
    applyStimulus(0, 5);
    repeat (6) stepCycle();

    $display("[TB] row 0 and row 15 near threshold levels");
    applyStimulus(1, 0, 0.85, 0.75);
    stepCycle();
    applyStimulus(0, 0);
    repeat (6) stepCycle();
    applyStimulus(1, 15, 0.85, 0.75);
    stepCycle();
    applyStimulus(0, 15);
    repeat (6) stepCycle();

    $display("[TB] busy and back-to-back");
    applyStimulus(1, 3);
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(1, 9);
    repeat (9) stepCycle();
    applyStimulus(0, 9);
    repeat (8) stepCycle();

    $display("[TB] out of range on ROWS=12");
    apply12(1, 13);
    stepCycle();
    apply12(0, 13);
    repeat (2) stepCycle();
    apply12(1, 12);
    stepCycle();
    apply12(0, 12);
    repeat (2) stepCycle();
    apply12(1, 11);
    stepCycle();
    apply12(0, 11);
    repeat (6) stepCycle();

    $display("[TB] reset mid-ACTIVE");
    applyStimulus(1, 7);
    stepCycle();
    applyStimulus(0, 7);
    stepCycle();
    stepCycle();
    #3;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    q12.delete();
    checkOutput(idleRec());
    check12(idleRec());
    curReady = 1'b1;
    cur12Ready = 1'b1;
    repeat (2) stepCycle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
